match_scorer: RTL
=================

# match_scorer

Parametrised tug-of-war scorer for multi-round matches. It tracks the rope position across a configurable number of steps per side, awards rounds, and counts round wins up to a match win. It drives a one-hot LED score word plus round and match status. It sits after the push arbiter, which supplies `winrnd`, `right` and `tie`, and the light sequencer, which supplies `leds_on`, and it drives the LED bank directly.

## Interface
- `HALF`, default 3: positions per side, legal range 1..7. Score width is 2*HALF+1.
- `WIN_ROUNDS`, default 2: rounds a player needs to win the match, legal range 1..15. Local `CW` = clog2(WIN_ROUNDS+1).
- `JUMP_MODE`, default 0: 0 = push with lights off is ignored; 1 = jump-the-light penalty applies.
- `PENALTY`, default 1: steps the rope moves on a jump-the-light push when JUMP_MODE=1, legal range 1..HALF.
- `CATCHUP`, default 1: 1 = favour-the-loser double step from the extreme position.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `winrnd` in 1: one-cycle pulse, a push has been arbitrated.
- `right` in 1: 1 = right player pushed first.
- `leds_on` in 1: lights were on at the time of the push.
- `tie` in 1: simultaneous push; blocks any update this cycle.
- `new_match` in 1: one-cycle pulse, clears the match.
- `score` out 2*HALF+1: LED word; MSB is the far-left LED, LSB is the far-right LED.
- `rounds_l`, `rounds_r` out CW: rounds won by each player.
- `round_won` out 1: high while in a WON_L or WON_R state.
- `match_over` out 1: high while in a MATCH_L or MATCH_R state.

## Operation
- States: RST, PLAY, WON_L, WON_R, MATCH_L, MATCH_R. `pos` is signed, range -HALF..+HALF; negative means left.
- `mr` = (right == leds_on). A proper right push or a left jump moves the rope right.
- Update priority, highest first:
  - `new_match`: `pos`=0, both counts=0, state=PLAY. Any `winrnd` in the same cycle is discarded.
  - `tie`: hold everything.
  - `winrnd`: act as below.
- RST goes to PLAY on the first rising edge after `rst` deasserts, regardless of inputs.
- PLAY, `leds_on`=1:
  - pos=+HALF and mr: right wins the round.
  - pos=-HALF and ~mr: left wins the round.
  - CATCHUP=1, pos=-HALF and mr: pos += min(2,HALF).
  - CATCHUP=1, pos=+HALF and ~mr: pos -= min(2,HALF).
  - Otherwise pos += 1 if mr, else pos -= 1.
- PLAY, `leds_on`=0:
  - JUMP_MODE=0: no change.
  - JUMP_MODE=1: pos moves PENALTY steps (right if mr, else left), saturating at ±HALF. A penalty never wins a round.
- Round win:
  - The winner's count increments.
  - If the new count equals WIN_ROUNDS, go to MATCH_L or MATCH_R. Otherwise go to WON_L or WON_R.
- WON_x: the next `winrnd` (any `right` or `leds_on` value, no tie) sets pos=0 and returns to PLAY. Counts are unchanged.
- MATCH_x: held until `new_match` or reset. `winrnd` is ignored.
- Score decode is combinational from state and pos, with index 2*HALF is leftmost:
  - RST: outer min(2,HALF) bits set on each side, all others clear.
  - PLAY: one-hot, bit index HALF-pos.
  - WON_L and MATCH_L: bits [2*HALF:HALF+1] set.
  - WON_R and MATCH_R: bits [HALF-1:0] set.
  - Illegal state: alternating pattern 1010…1, and the next state is RST.
- Counts never exceed WIN_ROUNDS and never wrap.

## Timing
- Reset, asynchronous and immediate on `rst`=0:
  - state=RST, pos=0, rounds_l=rounds_r=0.
  - `score`=RST pattern, `round_won`=0, `match_over`=0.
- All registered updates happen on the rising `clk` edge that samples the input pulse. Outputs reflect the change one cycle after the pulse is presented, with no further latency.
- A `winrnd` held high for k cycles is treated as k pushes. Upstream guarantees single-cycle pulses.
- Reset asserted mid-round or mid-match aborts immediately. The RST pattern is shown for exactly one cycle after release.
- Inputs are assumed synchronous to `clk`.

## Test plan
- Reset release, then 3 right proper pushes (HALF=3) -> score 0001000, 0000100, 0000010, 0000001; a 4th push -> 0000111, round_won=1, rounds_r=1.
- pos=-3, right proper push with CATCHUP=1 -> score 0010000 (pos=-1); with CATCHUP=0 -> 0100000.
- JUMP_MODE=0, `leds_on`=0 push -> score unchanged. JUMP_MODE=1, PENALTY=2, pos=+2, left jumps -> pos=+3 (saturated), no round win.
- WIN_ROUNDS=2: right wins 2 rounds, with one `winrnd` between them to restart -> match_over=1, score 0000111, rounds_r=2. Further `winrnd` pulses change nothing. `new_match` -> score 0001000, counts 0.
- `tie`=1 together with `winrnd` -> no change. `new_match` and `winrnd` in the same cycle -> pos=0, counts 0, push ignored.
- Assert `rst` low mid-round at pos=+2, rounds_l=1 -> outputs go to the reset values at once, without waiting for a clock edge. After release, score is 1100011 for one cycle, then 0001000.

Source files
------------

// File: rtl/match_scorer.sv
// match_scorer: tug-of-war scorer for multi-round matches.
// Tracks the rope position, awards rounds, counts round wins up to a match
// win and drives the LED bank directly.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-low reset
//   winrnd     in   one-cycle pulse, a push has been arbitrated
//   right      in   1 = right player pushed first
//   leds_on    in   lights were on at the time of the push
//   tie        in   simultaneous push, blocks any update this cycle
//   new_match  in   one-cycle pulse, clears the match
//   score      out  LED word, MSB = far-left LED, LSB = far-right LED
//   rounds_l   out  rounds won by the left player
//   rounds_r   out  rounds won by the right player
//   round_won  out  high in WON_L / WON_R
//   match_over out  high in MATCH_L / MATCH_R
//
// state   | meaning
// --------+---------------------------------------------------------------
// RST     | just out of reset, shows the reset pattern for one cycle
// PLAY    | round in progress, rope position is live
// WON_L   | left won the round, next push restarts play
// WON_R   | right won the round, next push restarts play
// MATCH_L | left won the match, held until new_match or reset
// MATCH_R | right won the match, held until new_match or reset
module match_scorer #(
  parameter int HALF       = 3,
  parameter int WIN_ROUNDS = 2,
  parameter int JUMP_MODE  = 0,
  parameter int PENALTY    = 1,
  parameter int CATCHUP    = 1,
  localparam int CW        = $clog2(WIN_ROUNDS + 1),
  localparam int SW        = 2 * HALF + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          winrnd,
  input  logic          right,
  input  logic          leds_on,
  input  logic          tie,
  input  logic          new_match,
  output logic [SW-1:0] score,
  output logic [CW-1:0] rounds_l,
  output logic [CW-1:0] rounds_r,
  output logic          round_won,
  output logic          match_over
);

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_PLAY    = 3'd1,
    ST_WON_L   = 3'd2,
    ST_WON_R   = 3'd3,
    ST_MATCH_L = 3'd4,
    ST_MATCH_R = 3'd5
  } state_t;

  // Five signed bits hold +-HALF plus a full penalty step before saturation.
  localparam int                STEP2_I = (HALF < 2) ? HALF : 2;
  localparam logic signed [4:0] P_MAX   = 5'(HALF);
  localparam logic signed [4:0] P_MIN   = -P_MAX;
  localparam logic signed [4:0] STEP2   = 5'(STEP2_I);
  localparam logic signed [4:0] PEN     = 5'(PENALTY);
  localparam logic signed [4:0] ONE     = 5'sd1;
  localparam logic [CW-1:0]     WR      = CW'(WIN_ROUNDS);

  state_t             state, state_nxt;
  logic signed [4:0]  pos, pos_nxt;
  logic [CW-1:0]      rl_nxt, rr_nxt;
  logic [CW-1:0]      rl_inc, rr_inc;
  logic signed [4:0]  jump_sum;
  logic               mr, push, win_l, win_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RST;
      pos      <= '0;
      rounds_l <= '0;
      rounds_r <= '0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      rounds_l <= rl_nxt;
      rounds_r <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    rl_nxt    = rounds_l;
    rr_nxt    = rounds_r;
    win_l     = 1'b0;
    win_r     = 1'b0;
    // A proper right push or a left jump both pull the rope to the right.
    mr        = (right == leds_on);
    push      = winrnd & ~tie & ~new_match;
    jump_sum  = mr ? (pos + PEN) : (pos - PEN);
    // Counts saturate so they can never wrap.
    rl_inc    = (rounds_l == WR) ? rounds_l : rounds_l + CW'(1);
    rr_inc    = (rounds_r == WR) ? rounds_r : rounds_r + CW'(1);

    case (state)
      ST_RST: begin
        state_nxt = ST_PLAY;
        pos_nxt   = '0;
      end
      ST_PLAY: begin
        if (push) begin
          if (leds_on) begin
            if (pos == P_MAX && mr)
              win_r = 1'b1;
            else if (pos == P_MIN && !mr)
              win_l = 1'b1;
            else if (CATCHUP != 0 && pos == P_MIN)
              pos_nxt = pos + STEP2;
            else if (CATCHUP != 0 && pos == P_MAX)
              pos_nxt = pos - STEP2;
            else
              pos_nxt = mr ? (pos + ONE) : (pos - ONE);
          end else if (JUMP_MODE != 0) begin
            // Penalty saturates at the extremes and never wins a round.
            if (jump_sum > P_MAX)
              pos_nxt = P_MAX;
            else if (jump_sum < P_MIN)
              pos_nxt = P_MIN;
            else
              pos_nxt = jump_sum;
          end
        end
        if (win_r) begin
          rr_nxt    = rr_inc;
          state_nxt = (rr_inc == WR) ? ST_MATCH_R : ST_WON_R;
        end
        if (win_l) begin
          rl_nxt    = rl_inc;
          state_nxt = (rl_inc == WR) ? ST_MATCH_L : ST_WON_L;
        end
      end
      ST_WON_L, ST_WON_R: begin
        if (push) begin
          pos_nxt   = '0;
          state_nxt = ST_PLAY;
        end
      end
      ST_MATCH_L, ST_MATCH_R: begin
      end
      default: begin
        state_nxt = ST_RST;
        pos_nxt   = '0;
        rl_nxt    = '0;
        rr_nxt    = '0;
      end
    endcase

    // new_match outranks tie and winrnd in every legal post-reset state.
    if (new_match && state inside {ST_PLAY, ST_WON_L, ST_WON_R,
                                   ST_MATCH_L, ST_MATCH_R}) begin
      state_nxt = ST_PLAY;
      pos_nxt   = '0;
      rl_nxt    = '0;
      rr_nxt    = '0;
    end
  end

  always_comb begin
    score = '0;
    case (state)
      ST_RST:
        for (int i = 0; i < SW; i++)
          score[i] = (i < STEP2_I) || (i >= SW - STEP2_I);
      ST_PLAY:
        for (int i = 0; i < SW; i++)
          score[i] = (i == HALF - int'(pos));
      ST_WON_L, ST_MATCH_L:
        for (int i = 0; i < SW; i++)
          score[i] = (i > HALF);
      ST_WON_R, ST_MATCH_R:
        for (int i = 0; i < SW; i++)
          score[i] = (i < HALF);
      default:
        for (int i = 0; i < SW; i++)
          score[i] = (i % 2 == 0);
    endcase
  end

  assign round_won  = (state == ST_WON_L)   || (state == ST_WON_R);
  assign match_over = (state == ST_MATCH_L) || (state == ST_MATCH_R);

endmodule
